// File: rtl/key_event_uart_tx_if.sv
// Scanner-event / UART-status bundle for key_event_uart_tx.
// The master side is the scanner and its supervisor. The slave side is the UART stage.
interface key_event_uart_tx_if #(
    parameter int FIFO_AW = 4
);
    logic               keyEventReady;
    logic [7:0]         keyEvent;
    logic               ovfClr;
    logic               txd;
    logic               txBusy;
    logic [FIFO_AW:0]   fifoCount;
    logic               ovfFlag;

    modport master (
        output keyEventReady, keyEvent, ovfClr,
        input  txd, txBusy, fifoCount, ovfFlag
    );

    modport slave (
        input  keyEventReady, keyEvent, ovfClr,
        output txd, txBusy, fifoCount, ovfFlag
    );
endinterface

// File: rtl/key_event_uart_tx.sv
// Captures scanner events, queues them in a FIFO and sends each one as a UART frame, LSB first.
// Define UART_PARITY_EN to get 8E1 frames with even parity. Without it the frames are 8N1.
module key_event_uart_tx #(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 4
) (
    input  logic                clk,
    input  logic                rst,
    key_event_uart_tx_if.slave  bus
);
    localparam int          DEPTH  = 2 ** FIFO_AW;
    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic             prev_ready;
    logic [7:0]       prev_code;
    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wptr, rptr;
    logic             full, empty, new_evt, pop, wr_en;

    state_t           state;
    logic [7:0]       shift_reg;
    logic [2:0]       bit_cnt;
    logic [15:0]      baud;
`ifdef UART_PARITY_EN
    logic             parity_bit;
`endif

    assign empty   = (wptr == rptr);
    assign full    = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                     (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    // Flags are levels: a byte is only produced on a rising ready or a changed code.
    assign new_evt = bus.keyEventReady && (!prev_ready || bus.keyEvent != prev_code) &&
                     (bus.keyEvent[7:6] != 2'b00);
    assign pop     = (state == IDLE) && !empty;
    assign wr_en   = new_evt && (!full || pop);
    assign bus.fifoCount = wptr - rptr;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[FIFO_AW-1:0]] <= bus.keyEvent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ready  <= 1'b0;
            prev_code   <= '0;
            wptr        <= '0;
            rptr        <= '0;
            bus.ovfFlag <= 1'b0;
        end else begin
            prev_ready <= bus.keyEventReady;
            prev_code  <= bus.keyEvent;
            if (wr_en) wptr <= wptr + 1'b1;
            if (pop)   rptr <= rptr + 1'b1;
            if (new_evt && full && !pop) bus.ovfFlag <= 1'b1;
            else if (bus.ovfClr)         bus.ovfFlag <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bus.txd    <= 1'b1;
            bus.txBusy <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            baud       <= '0;
`ifdef UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (pop) begin
                    shift_reg  <= mem[rptr[FIFO_AW-1:0]];
`ifdef UART_PARITY_EN
                    parity_bit <= ^mem[rptr[FIFO_AW-1:0]];
`endif
                    bus.txBusy <= 1'b1;
                    bus.txd    <= 1'b0;
                    baud       <= DIV_M1;
                    state      <= START;
                end
                START: if (baud == '0) begin
                    baud    <= DIV_M1;
                    bus.txd <= shift_reg[0];
                    bit_cnt <= '0;
                    state   <= DATA;
                end else baud <= baud - 1'b1;
                DATA: if (baud == '0) begin
                    baud <= DIV_M1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                        bus.txd <= parity_bit;
                        state   <= PARITY;
`else
                        bus.txd <= 1'b1;
                        state   <= STOP;
`endif
                    end else begin
                        bit_cnt   <= bit_cnt + 1'b1;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bus.txd   <= shift_reg[1];
                    end
                end else baud <= baud - 1'b1;
`ifdef UART_PARITY_EN
                PARITY: if (baud == '0) begin
                    baud    <= DIV_M1;
                    bus.txd <= 1'b1;
                    state   <= STOP;
                end else baud <= baud - 1'b1;
`endif
                STOP: if (baud == '0) begin
                    bus.txBusy <= 1'b0;
                    state      <= IDLE;
                end else baud <= baud - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_event_uart_tx.sv
// Scoreboard bench for key_event_uart_tx: expected bytes are queued at stimulus time and a txd
// monitor decodes every frame. Honours UART_PARITY_EN the same way the design does.
module tb_key_event_uart_tx;
    localparam int D  = 4;
    localparam int AW = 2;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME_CLK = FB * D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   frames = 0;
    logic [7:0] expq[$];
    int   starts[$];

    key_event_uart_tx_if #(.FIFO_AW(AW)) bus ();
    key_event_uart_tx #(.CLK_DIV(D), .FIFO_AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((expq.size() != 0 || bus.txBusy || bus.fifoCount != 0) && n < 3000) begin
            tick(1);
            n++;
        end
        check(tag, n < 3000, 1'b1);
        tick(3);
    endtask

    // Monitor: a low txd outside reset starts a frame; every bit must hold for D clocks.
    initial begin
        logic [10:0] obs, expv;
        logic        unstable, aborted, s;
        logic [7:0]  e;
        forever begin
            @(negedge clk);
            if (rst || bus.txd !== 1'b0) continue;
            starts.push_back(cyc);
            obs = '1; unstable = 1'b0; aborted = 1'b0;
            for (int i = 0; i < FB; i++) begin
                for (int j = 0; j < D; j++) begin
                    if (!(i == 0 && j == 0)) @(negedge clk);
                    s = bus.txd;
                    if (rst) aborted = 1'b1;
                    if (j == 0) obs[i] = s;
                    else if (s !== obs[i]) unstable = 1'b1;
                end
            end
            if (aborted) continue;
            check("frame_expected", expq.size() > 0, 1'b1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                expv = '1;
                expv[0] = 1'b0;
                expv[8:1] = e;
`ifdef UART_PARITY_EN
                expv[9] = ^e;
`endif
                check("frame_bits", 32'(obs), 32'(expv));
                check("bit_width", unstable, 1'b0);
            end
            frames++;
        end
    end

    initial begin
        int s0, f0;
        bus.keyEventReady = 1'b0;
        bus.keyEvent = '0;
        bus.ovfClr = 1'b0;

        // Reset and idle
        rst = 1'b1; tick(3); rst = 1'b0; tick(20);
        check("rst_txd", bus.txd, 1'b1);
        check("rst_busy", bus.txBusy, 1'b0);
        check("rst_count", bus.fifoCount, 0);
        check("rst_ovf", bus.ovfFlag, 1'b0);

        // Code with [7:6]=00 is never queued
        bus.keyEventReady = 1'b1; bus.keyEvent = 8'h05; tick(6);
        check("null_code_count", bus.fifoCount, 0);
        check("null_code_busy", bus.txBusy, 1'b0);
        bus.keyEventReady = 1'b0; tick(2);

        // Held event -> one frame, with write/pop latency
        f0 = frames;
        bus.keyEventReady = 1'b1; bus.keyEvent = 8'h45; expq.push_back(8'h45);
        tick(1);
        check("lat_count", bus.fifoCount, 1);
        check("lat_txd_hi", bus.txd, 1'b1);
        tick(1);
        check("lat_txd_lo", bus.txd, 1'b0);
        check("lat_busy", bus.txBusy, 1'b1);
        check("lat_popped", bus.fifoCount, 0);
        tick(48);
        bus.keyEventReady = 1'b0;
        wait_drain("drain_hold");
        check("hold_frames", frames - f0, 1);

        // Back-to-back frames with a 1-clk gap
        f0 = frames; s0 = starts.size();
        bus.keyEventReady = 1'b1;
        foreach (expq[i]) ;
        bus.keyEvent = 8'h41; expq.push_back(8'h41); tick(1);
        bus.keyEvent = 8'h81; expq.push_back(8'h81); tick(1);
        bus.keyEvent = 8'h57; expq.push_back(8'h57); tick(1);
        bus.keyEventReady = 1'b0;
        wait_drain("drain_b2b");
        check("b2b_frames", frames - f0, 3);
        if (starts.size() >= s0 + 3) begin
            check("gap_1", starts[s0+1] - starts[s0], FRAME_CLK + 1);
            check("gap_2", starts[s0+2] - starts[s0+1], FRAME_CLK + 1);
        end else check("b2b_starts", starts.size() - s0, 3);

        // Overflow: 6 events in 6 clocks, depth 4, first one pops immediately
        f0 = frames;
        bus.keyEventReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.keyEvent = 8'(8'h41 + i);
            if (i < 5) expq.push_back(8'(8'h41 + i));
            tick(1);
        end
        bus.keyEventReady = 1'b0;
        check("ovf_set", bus.ovfFlag, 1'b1);
        check("ovf_count", bus.fifoCount, 4);
        wait_drain("drain_ovf");
        check("ovf_frames", frames - f0, 5);
        check("ovf_sticky", bus.ovfFlag, 1'b1);
        bus.ovfClr = 1'b1; tick(1); bus.ovfClr = 1'b0;
        check("ovf_clr", bus.ovfFlag, 1'b0);

        // Clear and new overflow in the same cycle: set wins
        bus.keyEventReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.keyEvent = 8'(8'h81 + i);
            bus.ovfClr = (i == 5);
            if (i < 5) expq.push_back(8'(8'h81 + i));
            tick(1);
        end
        bus.keyEventReady = 1'b0; bus.ovfClr = 1'b0;
        check("ovf_set_wins", bus.ovfFlag, 1'b1);
        wait_drain("drain_ovf2");
        bus.ovfClr = 1'b1; tick(1); bus.ovfClr = 1'b0;

        // Reset during data bit 3
        f0 = frames;
        bus.keyEventReady = 1'b1;
        bus.keyEvent = 8'h49; expq.push_back(8'h49); tick(1);
        bus.keyEvent = 8'h4A; tick(1);
        bus.keyEvent = 8'h4B; tick(1);
        bus.keyEventReady = 1'b0;
        tick(4 * D);
        check("mid_bit3", bus.txd, 1'b1);
        rst = 1'b1; tick(1);
        expq.delete();
        check("abort_txd", bus.txd, 1'b1);
        check("abort_busy", bus.txBusy, 1'b0);
        check("abort_count", bus.fifoCount, 0);
        rst = 1'b0; tick(100);
        check("abort_frames", frames - f0, 0);
        check("abort_idle_txd", bus.txd, 1'b1);

`ifdef UART_PARITY_EN
        // Parity: 0x43 has three ones, 0x47 has four; frames 44 clk apart plus the gap
        f0 = frames; s0 = starts.size();
        bus.keyEventReady = 1'b1;
        bus.keyEvent = 8'h43; expq.push_back(8'h43); tick(1);
        bus.keyEvent = 8'h47; expq.push_back(8'h47); tick(1);
        bus.keyEventReady = 1'b0;
        wait_drain("drain_par");
        check("par_frames", frames - f0, 2);
        if (starts.size() >= s0 + 2) check("par_len", starts[s0+1] - starts[s0], 45);
`endif

        check("sb_empty", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
